// File: rtl/simon_game_ctrl.sv
// Simon Says controller: owns the colour sequence, plays it back on pulse ticks and checks the player's presses.
// Single-cycle states except where waiting on keys/pulse/buttons; optional turn timeout under SIMON_TURN_TIMEOUT_EN.
module simon_game_ctrl #(
  parameter int NUM_BTN      = 4,
  parameter int MAX_ROUNDS   = 32,
  parameter int SPEED_STEP   = 5,
  parameter int DEBOUNCE_CYC = 20000000,
  parameter int FAIL_FLASHES = 3,
`ifdef SIMON_TURN_TIMEOUT_EN
  parameter int TIMEOUT_PULSES = 8,
`endif
  localparam int CW = $clog2(NUM_BTN),
  localparam int RW = $clog2(MAX_ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         launch_keys,
  input  logic [NUM_BTN-1:0] player_input,
  input  logic               pulse,
  input  logic [CW-1:0]      rng_value,
  output logic               rng_seed_rst,
  output logic               rng_start,
  output logic [3:0]         speed,
  output logic [NUM_BTN-1:0] led,
  output logic [RW-1:0]      current_round,
  output logic               win,
  output logic               fail,
  output logic [4:0]         state_dbg
);

  localparam logic [4:0] IDLE      = 5'd0;
  localparam logic [4:0] SEED      = 5'd1;
  localparam logic [4:0] ARM       = 5'd2;
  localparam logic [4:0] START     = 5'd3;
  localparam logic [4:0] HOLD      = 5'd4;
  localparam logic [4:0] ADD       = 5'd5;
  localparam logic [4:0] SPEED     = 5'd6;
  localparam logic [4:0] SHOW_WAIT = 5'd7;
  localparam logic [4:0] SHOW_ON   = 5'd8;
  localparam logic [4:0] SHOW_OFF  = 5'd9;
  localparam logic [4:0] TURN      = 5'd10;
  localparam logic [4:0] CHECK     = 5'd11;
  localparam logic [4:0] RELEASE   = 5'd12;
  localparam logic [4:0] DEBOUNCE  = 5'd13;
  localparam logic [4:0] NEXT      = 5'd14;
  localparam logic [4:0] FAIL_ON   = 5'd15;
  localparam logic [4:0] FAIL_OFF  = 5'd16;
  localparam logic [4:0] WIN       = 5'd17;
  localparam logic [4:0] END       = 5'd18;

  localparam int DEPTH = 1 << RW;
  localparam int SW    = $clog2(SPEED_STEP + 1);
  localparam int DW    = $clog2(DEBOUNCE_CYC + 1);
  localparam int FW    = $clog2(FAIL_FLASHES + 1);

  logic [4:0]         state, state_nx;
  logic               first_cyc;
  logic               pulse_ok;
  logic [CW-1:0]      mem [0:DEPTH-1];
  logic [RW-1:0]      round, idx;
  logic [SW-1:0]      step_cnt;
  logic [DW-1:0]      cnt;
  logic [FW-1:0]      flash;
  logic [NUM_BTN-1:0] latch;
  logic [CW-1:0]      rng_fix;
  logic [NUM_BTN-1:0] cur_oh;
  logic               speed_due;
  logic               good;
  logic               seq_done;
  logic               last_flash;
  logic               timeout;

  // A pulse landing on the entry cycle of a state belongs to the previous state.
  assign pulse_ok   = pulse & ~first_cyc;
  assign rng_fix    = ({1'b0, rng_value} >= (CW+1)'(NUM_BTN)) ? rng_value - CW'(NUM_BTN) : rng_value;
  assign cur_oh     = NUM_BTN'(1) << mem[idx];
  assign speed_due  = (step_cnt == SW'(SPEED_STEP - 1));
  assign good       = (latch == cur_oh);
  assign seq_done   = !((idx + RW'(1)) < round);
  assign last_flash = ((flash + FW'(1)) == FW'(FAIL_FLASHES));

`ifdef SIMON_TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_PULSES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != TURN) begin
      to_cnt <= '0;
    end else if (pulse_ok) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign timeout = (state == TURN) && (player_input == '0) && pulse_ok &&
                   (to_cnt == TW'(TIMEOUT_PULSES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (launch_keys[0]) state_nx = SEED;
      SEED:      state_nx = ARM;
      ARM:       if (launch_keys == 2'b11) state_nx = START;
      START:     state_nx = HOLD;
      HOLD:      if (launch_keys == 2'b00) state_nx = ADD;
      ADD:       state_nx = speed_due ? SPEED : SHOW_WAIT;
      SPEED:     state_nx = SHOW_WAIT;
      SHOW_WAIT: if (pulse_ok) state_nx = (idx < round) ? SHOW_ON : TURN;
      SHOW_ON:   if (pulse_ok) state_nx = SHOW_OFF;
      SHOW_OFF:  state_nx = SHOW_WAIT;
      TURN: begin
        if (player_input != '0) state_nx = CHECK;
        else if (timeout)       state_nx = FAIL_ON;
      end
      CHECK:     state_nx = good ? RELEASE : FAIL_ON;
      RELEASE:   if (player_input == '0) state_nx = DEBOUNCE;
      DEBOUNCE:  if (player_input == '0 && cnt == '0) state_nx = NEXT;
      NEXT: begin
        if (!seq_done)                        state_nx = TURN;
        else if (round == RW'(MAX_ROUNDS))    state_nx = WIN;
        else                                  state_nx = ADD;
      end
      FAIL_ON:   if (pulse_ok) state_nx = FAIL_OFF;
      FAIL_OFF:  if (pulse_ok) state_nx = last_flash ? END : FAIL_ON;
      WIN:       state_nx = END;
      END:       state_nx = END;
      default:   state_nx = IDLE;
    endcase
  end

  // Sequence storage is never cleared; only entries below round are ever read.
  always_ff @(posedge clk) begin
    if (state == ADD) mem[round] <= rng_fix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      first_cyc     <= 1'b1;
      round         <= '0;
      idx           <= '0;
      step_cnt      <= '0;
      cnt           <= '0;
      flash         <= '0;
      latch         <= '0;
      speed         <= '0;
      current_round <= '0;
      win           <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state     <= state_nx;
      first_cyc <= (state_nx != state);
      case (state)
        ADD: begin
          round    <= round + RW'(1);
          idx      <= '0;
          step_cnt <= speed_due ? '0 : step_cnt + SW'(1);
        end
        SPEED:     if (speed != 4'd15) speed <= speed + 4'd1;
        SHOW_WAIT: if (pulse_ok && !(idx < round)) idx <= '0;
        SHOW_OFF:  idx <= idx + RW'(1);
        TURN: begin
          if (player_input != '0) begin
            latch <= player_input;
          end else if (timeout) begin
            flash         <= '0;
            current_round <= round - RW'(1);
          end
        end
        CHECK: begin
          if (!good) begin
            flash         <= '0;
            current_round <= round - RW'(1);
          end
        end
        RELEASE:   if (player_input == '0) cnt <= DW'(DEBOUNCE_CYC - 1);
        DEBOUNCE: begin
          if (player_input != '0) cnt <= DW'(DEBOUNCE_CYC - 1);
          else if (cnt != '0)     cnt <= cnt - DW'(1);
        end
        NEXT: begin
          idx <= idx + RW'(1);
          if (seq_done && round != RW'(MAX_ROUNDS)) current_round <= round;
        end
        FAIL_OFF: begin
          if (pulse_ok) begin
            flash <= flash + FW'(1);
            if (last_flash) fail <= 1'b1;
          end
        end
        WIN: begin
          win           <= 1'b1;
          current_round <= RW'(MAX_ROUNDS);
        end
        default: ;
      endcase
    end
  end

  assign rng_seed_rst = (state == SEED);
  assign rng_start    = (state == START);
  assign led          = (state == SHOW_ON || state == FAIL_ON) ? cur_oh : '0;
  assign state_dbg    = state;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Bench for simon_game_ctrl: win, wrong-move, debounce, multi-hot and mid-game reset scenarios.
module tb_simon_game_ctrl;

  localparam int P = 4;
  localparam logic [4:0] S_IDLE = 5'd0, S_SEED = 5'd1, S_SHOW_ON = 5'd8, S_SHOW_OFF = 5'd9,
                         S_TURN = 5'd10, S_DEBOUNCE = 5'd13, S_FAIL_ON = 5'd15,
                         S_FAIL_OFF = 5'd16, S_END = 5'd18;

  typedef struct packed {
    logic [1:0] rng;
    logic [3:0] spd;
    logic [1:0] cur;
  } round_vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] launch_keys = 2'b00;
  logic [3:0] player_input = 4'b0;
  logic       pulse = 1'b0;
  logic [1:0] rng_value = 2'd0;
  logic       rng_seed_rst, rng_start, win, fail;
  logic [3:0] speed, led;
  logic [1:0] current_round;
  logic [4:0] state_dbg;

  logic [4:0] player_input2 = 5'b0;
  logic [2:0] rng_value2 = 3'd5;
  logic       rng_seed_rst2, rng_start2, win2, fail2;
  logic [3:0] speed2;
  logic [4:0] led2;
  logic [1:0] current_round2;
  logic [4:0] state_dbg2;

  int         errors = 0;
  int         checks = 0;
  int         fon_cnt = 0;
  int         on_len = 0;
  logic [4:0] prev = 5'd0, prev2 = 5'd0;
  logic [4:0] led2_seen = 5'h1f;
  logic [3:0] exp_q[$];
  logic [1:0] seq[3];
  round_vec_t vec[3];

  simon_game_ctrl #(.NUM_BTN(4), .MAX_ROUNDS(3), .SPEED_STEP(2), .DEBOUNCE_CYC(4),
                    .FAIL_FLASHES(3)) dut (
    .clk(clk), .reset(reset), .launch_keys(launch_keys), .player_input(player_input),
    .pulse(pulse), .rng_value(rng_value), .rng_seed_rst(rng_seed_rst), .rng_start(rng_start),
    .speed(speed), .led(led), .current_round(current_round), .win(win), .fail(fail),
    .state_dbg(state_dbg));

  simon_game_ctrl #(.NUM_BTN(5), .MAX_ROUNDS(3), .SPEED_STEP(2), .DEBOUNCE_CYC(4),
                    .FAIL_FLASHES(3)) dut2 (
    .clk(clk), .reset(reset), .launch_keys(launch_keys), .player_input(player_input2),
    .pulse(pulse), .rng_value(rng_value2), .rng_seed_rst(rng_seed_rst2), .rng_start(rng_start2),
    .speed(speed2), .led(led2), .current_round(current_round2), .win(win2), .fail(fail2),
    .state_dbg(state_dbg2));

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (P - 1) @(negedge clk);
      pulse = 1'b1;
      @(negedge clk);
      pulse = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] oh(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_state(input logic [4:0] s, input string nm);
    int n;
    n = 0;
    while (state_dbg !== s && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (state_dbg !== s) begin
      checks++;
      errors++;
      $display("FAIL wait_%s: state %0d, want %0d", nm, state_dbg, s);
    end
  endtask

  task automatic press(input logic [3:0] v, input int hold);
    player_input = v;
    repeat (hold) @(negedge clk);
    player_input = 4'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    launch_keys = 2'b00;
    player_input = 4'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Ends on the HOLD cycle with the keys already released.
  task automatic start_game();
    @(negedge clk);
    launch_keys = 2'b01;
    @(negedge clk);
    chk("seed_state", 32'(state_dbg), 32'(S_SEED));
    chk("seed_pulse_hi", 32'(rng_seed_rst), 1);
    @(negedge clk);
    chk("seed_pulse_lo", 32'(rng_seed_rst), 0);
    launch_keys = 2'b11;
    @(negedge clk);
    chk("start_pulse_hi", 32'(rng_start), 1);
    @(negedge clk);
    chk("start_pulse_lo", 32'(rng_start), 0);
    launch_keys = 2'b00;
  endtask

  task automatic push_show(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(oh(seq[i]));
  endtask

  // Show monitor: pops the expected colour on each SHOW_ON entry and times its length.
  initial begin
    forever begin
      @(negedge clk);
      if (state_dbg == S_SHOW_ON && prev != S_SHOW_ON) begin
        on_len = 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL show_extra: led %0h shown with nothing expected", led);
        end else begin
          chk("show_led", 32'(led), 32'(exp_q.pop_front()));
        end
      end else if (state_dbg == S_SHOW_ON) begin
        on_len++;
      end
      if (prev == S_SHOW_ON && state_dbg == S_SHOW_OFF) begin
        chk("show_len", on_len, P);
        chk("show_off_led", 32'(led), 0);
      end
      if (state_dbg == S_FAIL_ON && prev != S_FAIL_ON) fon_cnt++;
      if (state_dbg2 == S_SHOW_ON && prev2 != S_SHOW_ON) led2_seen = led2;
      prev  = state_dbg;
      prev2 = state_dbg2;
    end
  end

  initial begin
    int f0;
    int n;
    vec[0] = '{rng: 2'd2, spd: 4'd0, cur: 2'd0};
    vec[1] = '{rng: 2'd1, spd: 4'd1, cur: 2'd1};
    vec[2] = '{rng: 2'd3, spd: 4'd1, cur: 2'd2};

    do_reset();
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_led", 32'(led), 0);
    chk("rst_speed", 32'(speed), 0);
    chk("rst_round", 32'(current_round), 0);
    chk("rst_flags", 32'({rng_seed_rst, rng_start, win, fail}), 0);
    chk("rst_dut2", 32'({rng_seed_rst2, rng_start2, speed2, led2, current_round2, win2, fail2}), 0);

    // Winning game driven from the round table.
    start_game();
    for (int r = 0; r < 3; r++) begin
      rng_value = vec[r].rng;
      seq[r] = vec[r].rng;
      push_show(r + 1);
      for (int k = 0; k <= r; k++) begin
        wait_state(S_TURN, "turn_win");
        if (k == 0) begin
          chk("turn_speed", 32'(speed), 32'(vec[r].spd));
          chk("turn_round", 32'(current_round), 32'(vec[r].cur));
        end
        press(oh(seq[k]), 2);
      end
    end
    wait_state(S_END, "end_win");
    chk("win_flag", 32'(win), 1);
    chk("win_fail_flag", 32'(fail), 0);
    chk("win_round", 32'(current_round), 3);
    chk("win_speed", 32'(speed), 1);
    chk("win_led", 32'(led), 0);
    chk("wrap_rng5", 32'(led2_seen), 32'h01);

    // Wrong colour in round 2.
    do_reset();
    start_game();
    rng_value = 2'd2;
    seq[0] = 2'd2;
    push_show(1);
    wait_state(S_TURN, "turn_f1");
    press(4'b0100, 2);
    rng_value = 2'd1;
    seq[1] = 2'd1;
    push_show(2);
    wait_state(S_TURN, "turn_f2a");
    press(4'b0100, 2);
    wait_state(S_TURN, "turn_f2b");
    f0 = fon_cnt;
    press(4'b0001, 2);
    for (int f = 0; f < 3; f++) begin
      wait_state(S_FAIL_ON, "fail_on");
      chk("flash_led", 32'(led), 32'h2);
      if (f == 0) chk("fail_round", 32'(current_round), 1);
      wait_state(S_FAIL_OFF, "fail_off");
      chk("flash_off_led", 32'(led), 0);
    end
    wait_state(S_END, "end_fail");
    chk("fail_flag", 32'(fail), 1);
    chk("fail_win_flag", 32'(win), 0);
    chk("fail_end_round", 32'(current_round), 1);
    chk("flash_count", fon_cnt - f0, 3);

    // Bounce during debounce, then a multi-hot press.
    do_reset();
    start_game();
    rng_value = 2'd2;
    seq[0] = 2'd2;
    push_show(1);
    wait_state(S_TURN, "turn_d1");
    press(4'b0100, 2);
    rng_value = 2'd1;
    seq[1] = 2'd1;
    push_show(2);
    wait_state(S_DEBOUNCE, "debounce");
    n = 0;
    while (state_dbg == S_DEBOUNCE && n < 50) begin
      n++;
      player_input = (n == 2) ? 4'b0001 : 4'b0000;
      @(negedge clk);
    end
    player_input = 4'b0;
    chk("debounce_len", n, 6);
    wait_state(S_TURN, "turn_d2");
    press(4'b0110, 2);
    wait_state(S_FAIL_ON, "multi_fail_on");
    chk("multi_flash_led", 32'(led), 32'h4);
    chk("multi_round", 32'(current_round), 1);
    wait_state(S_END, "end_multi");
    chk("multi_fail_flag", 32'(fail), 1);

    // Reset while a colour is being shown.
    do_reset();
    start_game();
    rng_value = 2'd3;
    seq[0] = 2'd3;
    push_show(1);
    wait_state(S_SHOW_ON, "show_on");
    chk("pre_rst_led", 32'(led), 32'h8);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("midrst_led", 32'(led), 0);
    chk("midrst_outs", 32'({speed, current_round, win, fail, rng_seed_rst, rng_start}), 0);
    reset = 1'b0;
    @(negedge clk);

    chk("show_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simon_game_ctrl.md
Name: simon_game_ctrl

Overview:
- Parametrised next-generation Simon Says game controller with NUM_BTN colour buttons, MAX_ROUNDS rounds and configurable debounce, speed-up and fail-flash behaviour.
- Owns the colour sequence memory, so move checking happens internally and no external result signal is needed.
- Sits between the launch keys/player buttons, the external RNG, and the pulse-generating speed timer; it drives the colour LEDs directly.

Parameters:
- NUM_BTN, 4, number of colour buttons/LEDs (2..8).
- MAX_ROUNDS, 32, rounds to complete for a win (1..64).
- SPEED_STEP, 5, speed increments after every SPEED_STEP-th round is added.
- DEBOUNCE_CYC, 20000000, clk cycles all inputs must stay low after a release.
- FAIL_FLASHES, 3, on/off flash pairs shown on a wrong move.
- CW, $clog2(NUM_BTN), width of a colour index (derived localparam).
- RW, $clog2(MAX_ROUNDS+1), width of the round counter (derived localparam).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- launch_keys  in  2  start keys, active-high.
- player_input  in  NUM_BTN  player buttons, active-high, already synchronised.
- pulse  in  1  single-cycle tick from the speed timer.
- rng_value  in  CW  current RNG output.
- rng_seed_rst  out  1  one-cycle RNG seed reset.
- rng_start  out  1  one-cycle RNG start.
- speed  out  4  speed level for the timer; saturates at 15.
- led  out  NUM_BTN  one-hot colour LED drive.
- current_round  out  RW  last fully passed round.
- win  out  1  sticky, set when the game is won.
- fail  out  1  sticky, set when the game is lost.
- state_dbg  out  5  current state encoding.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; sequence memory contents don't-care.
- Every state below lasts one cycle unless a wait condition is stated.
- IDLE: go to SEED when launch_keys[0]=1.
- SEED: rng_seed_rst=1 -> ARM.
- ARM: wait for launch_keys==2'b11 -> START.
- START: rng_start=1 -> HOLD.
- HOLD: wait for launch_keys==0 -> ADD.
- ADD: mem[round] <= rng_value; if rng_value >= NUM_BTN, store rng_value-NUM_BTN instead; round <= round+1.
  - Next is SPEED if the new round % SPEED_STEP == 0, else SHOW_WAIT with idx=0.
- SPEED: speed <= min(speed+1, 15) -> SHOW_WAIT.
- SHOW_WAIT: wait for pulse; then SHOW_ON if idx<round, else TURN with idx=0.
- SHOW_ON: led=onehot(mem[idx]); wait for pulse -> SHOW_OFF.
- SHOW_OFF: led=0; idx++ -> SHOW_WAIT.
- TURN: wait for player_input!=0 -> CHECK, latching player_input.
- CHECK: good if the latch equals onehot(mem[idx]); multi-hot is always a bad move.
  - Good -> RELEASE.
  - Bad -> FAIL_ON with flash=0 and current_round <= round-1.
- RELEASE: wait for player_input==0 -> DEBOUNCE with cnt=DEBOUNCE_CYC-1.
- DEBOUNCE: decrement cnt each cycle.
  - Any nonzero player_input reloads cnt.
  - At cnt==0 go to NEXT.
- NEXT: idx++.
  - If idx+1 < round -> TURN.
  - Else if round==MAX_ROUNDS -> WIN.
  - Else -> ADD, with current_round <= round.
- FAIL_ON: led=onehot(mem[idx]) (the expected colour); wait for pulse -> FAIL_OFF.
- FAIL_OFF: led=0; wait for pulse; flash++; if flash==FAIL_FLASHES -> END with fail=1, else FAIL_ON.
- WIN: win=1; current_round=MAX_ROUNDS -> END.
- END: hold until reset.
- Launch keys are ignored after HOLD; player_input is ignored outside TURN/RELEASE/DEBOUNCE.
- pulse coincident with a state entry is not consumed; it is first sampled in the state's second cycle.
- Reset mid-game: next cycle is IDLE with all outputs cleared.
- Never-reached state encodings go to IDLE.

Optional Feature:
- Macro SIMON_TURN_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_PULSES (default 8).
  - In TURN, count pulses; reaching TIMEOUT_PULSES with no press is a bad move and goes to FAIL_ON.
  - The counter clears on entry to TURN.
- Undefined: TURN waits indefinitely; no counter logic is present.

Test Plan (NUM_BTN=4, MAX_ROUNDS=3, SPEED_STEP=2, DEBOUNCE_CYC=4, FAIL_FLASHES=3):
- Start: keys 01 -> rng_seed_rst pulses 1 cycle; then keys 11 -> rng_start pulses 1 cycle; then keys 00 -> ADD stores rng_value=2.
- Show: after 2 pulses, led=4'b0100 for exactly one pulse interval, then led=0; state reaches TURN.
- Win: rng 2,1,3; correct presses each round -> speed=1 after round 2; win=1; current_round=3.
- Fail: in round 2, press 4'b0001 when 4'b0010 is expected -> led flashes 4'b0010 three times; fail=1; current_round=1.
- Debounce: a bounce high on cycle 2 of DEBOUNCE -> NEXT is delayed until 4 clean cycles; multi-hot 4'b0110 -> fail.
- Reset in SHOW_ON: led=0 and state IDLE one cycle later; rng_value=5 with CW=3, NUM_BTN=5 stores 0.
